// File: rtl/bp_maint_ctrl.sv
// bp_maint_ctrl: maintenance controller and write-port scheduler for the
// branch predictor tables (BTB and 2-bit PHT).
//
// This block invalidates both tables after reset and on every flush
// request. It also owns the single table write port and shares it between
// the sweep engine and commit-stage training updates. Updates that arrive
// while the port is busy are held in a small FIFO.
//
// Ports
//   clk_i, rst_i             clock; synchronous active-high reset
//   flush_req_i              one-cycle pulse that restarts the invalidation sweep
//   upd_*_i                  commit-stage training update (valid, targets, payload)
//   btb_wr*_o                BTB write port (enable, index, valid bit, tag, target)
//   pht_wr*_o                PHT write port (enable, index); pht_force_o, pht_taken_o
//   busy_o                   a sweep is in progress; Fetch ignores predictions
//   upd_drop_o               an update was discarded because the FIFO was full
module bp_maint_ctrl #(
    parameter int unsigned BTB_INDEX_WIDTH = 6,
    parameter int unsigned PHT_INDEX_WIDTH = 8,
    parameter int unsigned UPD_FIFO_DEPTH  = 4
) (
    input  logic                              clk_i,
    input  logic                              rst_i,
    input  logic                              flush_req_i,
    input  logic                              upd_valid_i,
    input  logic                              upd_btb_wr_i,
    input  logic                              upd_pht_wr_i,
    input  logic [BTB_INDEX_WIDTH-1:0]        upd_btb_index_i,
    input  logic [PHT_INDEX_WIDTH-1:0]        upd_pht_index_i,
    input  logic [32-BTB_INDEX_WIDTH-3:0]     upd_tag_i,
    input  logic [31:0]                       upd_target_i,
    input  logic                              upd_taken_i,
    output logic                              btb_wren_o,
    output logic [BTB_INDEX_WIDTH-1:0]        btb_wr_index_o,
    output logic                              btb_wr_valid_o,
    output logic [32-BTB_INDEX_WIDTH-3:0]     btb_wr_tag_o,
    output logic [31:0]                       btb_wr_target_o,
    output logic                              pht_wren_o,
    output logic [PHT_INDEX_WIDTH-1:0]        pht_wr_index_o,
    output logic                              pht_force_o,
    output logic                              pht_taken_o,
    output logic                              busy_o,
    output logic                              upd_drop_o
);

    localparam int unsigned TAG_W = 32 - BTB_INDEX_WIDTH - 2;
    localparam int unsigned MAX_W = (BTB_INDEX_WIDTH > PHT_INDEX_WIDTH) ? BTB_INDEX_WIDTH
                                                                        : PHT_INDEX_WIDTH;
    localparam int unsigned CNT_W = MAX_W + 1;
    localparam int unsigned FA_W  = $clog2(UPD_FIFO_DEPTH);
    localparam int unsigned FP_W  = FA_W + 1;

    localparam logic [CNT_W-1:0] SWEEP_LEN = CNT_W'(1 << MAX_W);
    localparam logic [CNT_W-1:0] BTB_LEN   = CNT_W'(1 << BTB_INDEX_WIDTH);
    localparam logic [CNT_W-1:0] PHT_LEN   = CNT_W'(1 << PHT_INDEX_WIDTH);

    typedef struct packed {
        logic                       btb_wr;
        logic                       pht_wr;
        logic [BTB_INDEX_WIDTH-1:0] btb_idx;
        logic [PHT_INDEX_WIDTH-1:0] pht_idx;
        logic [TAG_W-1:0]           tag;
        logic [31:0]                target;
        logic                       taken;
    } upd_t;

    typedef enum logic [1:0] {ST_INIT, ST_RUN, ST_FLUSH} state_t;

    state_t                     state_q, state_d;
    logic [CNT_W-1:0]           cnt_q, cnt_d;
    logic [FP_W-1:0]            wr_ptr_q, wr_ptr_d;
    logic [FP_W-1:0]            rd_ptr_q, rd_ptr_d;
    upd_t                       upd_mem_q [UPD_FIFO_DEPTH];

    logic                       btb_wren_q, btb_wren_d;
    logic [BTB_INDEX_WIDTH-1:0] btb_idx_q, btb_idx_d;
    logic                       btb_valid_q, btb_valid_d;
    logic [TAG_W-1:0]           btb_tag_q, btb_tag_d;
    logic [31:0]                btb_target_q, btb_target_d;
    logic                       pht_wren_q, pht_wren_d;
    logic [PHT_INDEX_WIDTH-1:0] pht_idx_q, pht_idx_d;
    logic                       pht_force_q, pht_force_d;
    logic                       pht_taken_q, pht_taken_d;
    logic                       busy_q, busy_d;
    logic                       upd_drop_q, upd_drop_d;

    upd_t                       upd_in_c, port_upd_c;
    logic                       upd_accept_c, fifo_empty_c, fifo_full_c;
    logic                       push_c, buffer_c, port_en_c;
    logic [CNT_W-1:0]           sweep_idx_c;

    assign upd_in_c     = '{btb_wr:  upd_btb_wr_i,    pht_wr:  upd_pht_wr_i,
                            btb_idx: upd_btb_index_i, pht_idx: upd_pht_index_i,
                            tag:     upd_tag_i,       target:  upd_target_i,
                            taken:   upd_taken_i};
    assign upd_accept_c = upd_valid_i & (upd_btb_wr_i | upd_pht_wr_i);

    // Pointers carry one extra wrap bit so that full and empty can be told apart.
    assign fifo_empty_c = (wr_ptr_q == rd_ptr_q);
    assign fifo_full_c  = (wr_ptr_q[FA_W] != rd_ptr_q[FA_W]) &&
                          (wr_ptr_q[FA_W-1:0] == rd_ptr_q[FA_W-1:0]);

    // Next state, sweep engine, port arbitration and FIFO control.
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        wr_ptr_d     = wr_ptr_q;
        rd_ptr_d     = rd_ptr_q;
        push_c       = 1'b0;
        buffer_c     = 1'b0;
        port_en_c    = 1'b0;
        port_upd_c   = upd_in_c;
        sweep_idx_c  = flush_req_i ? '0 : cnt_q;
        busy_d       = 1'b1;
        upd_drop_d   = 1'b0;
        btb_wren_d   = 1'b0;
        btb_idx_d    = '0;
        btb_valid_d  = 1'b0;
        btb_tag_d    = '0;
        btb_target_d = '0;
        pht_wren_d   = 1'b0;
        pht_idx_d    = '0;
        pht_force_d  = 1'b0;
        pht_taken_d  = 1'b0;

        case (state_q)
            ST_INIT, ST_FLUSH: begin
                buffer_c = 1'b1;
                // A flush during a sweep restarts it: index 0 is issued on this edge.
                if (sweep_idx_c < SWEEP_LEN) begin
                    btb_wren_d  = (sweep_idx_c < BTB_LEN);
                    pht_wren_d  = (sweep_idx_c < PHT_LEN);
                    btb_idx_d   = sweep_idx_c[BTB_INDEX_WIDTH-1:0];
                    pht_idx_d   = sweep_idx_c[PHT_INDEX_WIDTH-1:0];
                    pht_force_d = 1'b1;
                    cnt_d       = sweep_idx_c + CNT_W'(1);
                end else begin
                    state_d = ST_RUN;
                    busy_d  = 1'b0;
                end
            end
            ST_RUN: begin
                if (flush_req_i) begin
                    state_d  = ST_FLUSH;
                    cnt_d    = '0;
                    buffer_c = 1'b1;
                end else begin
                    busy_d = 1'b0;
                    // Pending updates go first. A new update is queued behind them.
                    if (!fifo_empty_c) begin
                        port_en_c  = 1'b1;
                        port_upd_c = upd_mem_q[rd_ptr_q[FA_W-1:0]];
                        rd_ptr_d   = rd_ptr_q + FP_W'(1);
                        push_c     = upd_accept_c;
                    end else begin
                        port_en_c  = upd_accept_c;
                    end
                end
            end
            default: state_d = ST_INIT;
        endcase

        if (buffer_c && upd_accept_c) begin
            if (fifo_full_c) begin
                upd_drop_d = 1'b1;
            end else begin
                push_c = 1'b1;
            end
        end

        if (push_c) begin
            wr_ptr_d = wr_ptr_q + FP_W'(1);
        end

        if (port_en_c) begin
            btb_wren_d   = port_upd_c.btb_wr;
            btb_idx_d    = port_upd_c.btb_idx;
            btb_valid_d  = 1'b1;
            btb_tag_d    = port_upd_c.tag;
            btb_target_d = port_upd_c.target;
            pht_wren_d   = port_upd_c.pht_wr;
            pht_idx_d    = port_upd_c.pht_idx;
            pht_force_d  = 1'b0;
            pht_taken_d  = port_upd_c.taken;
        end
    end

    // Control and output registers.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q      <= ST_INIT;
            cnt_q        <= '0;
            wr_ptr_q     <= '0;
            rd_ptr_q     <= '0;
            btb_wren_q   <= 1'b0;
            btb_idx_q    <= '0;
            btb_valid_q  <= 1'b0;
            btb_tag_q    <= '0;
            btb_target_q <= '0;
            pht_wren_q   <= 1'b0;
            pht_idx_q    <= '0;
            pht_force_q  <= 1'b0;
            pht_taken_q  <= 1'b0;
            busy_q       <= 1'b1;
            upd_drop_q   <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            wr_ptr_q     <= wr_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            btb_wren_q   <= btb_wren_d;
            btb_idx_q    <= btb_idx_d;
            btb_valid_q  <= btb_valid_d;
            btb_tag_q    <= btb_tag_d;
            btb_target_q <= btb_target_d;
            pht_wren_q   <= pht_wren_d;
            pht_idx_q    <= pht_idx_d;
            pht_force_q  <= pht_force_d;
            pht_taken_q  <= pht_taken_d;
            busy_q       <= busy_d;
            upd_drop_q   <= upd_drop_d;
        end
    end

    // FIFO storage. It has no reset because the pointers define which entries are valid.
    always_ff @(posedge clk_i) begin
        if (push_c) begin
            upd_mem_q[wr_ptr_q[FA_W-1:0]] <= upd_in_c;
        end
    end

    assign btb_wren_o      = btb_wren_q;
    assign btb_wr_index_o  = btb_idx_q;
    assign btb_wr_valid_o  = btb_valid_q;
    assign btb_wr_tag_o    = btb_tag_q;
    assign btb_wr_target_o = btb_target_q;
    assign pht_wren_o      = pht_wren_q;
    assign pht_wr_index_o  = pht_idx_q;
    assign pht_force_o     = pht_force_q;
    assign pht_taken_o     = pht_taken_q;
    assign busy_o          = busy_q;
    assign upd_drop_o      = upd_drop_q;

endmodule

// File: tb/tb_bp_maint_ctrl.sv
// Testbench for bp_maint_ctrl with small tables (4-entry BTB, 8-entry PHT, 4-deep FIFO).
// Expected port writes are queued as stimulus is driven, and a negedge monitor
// compares every write against that queue. Cycle timing is checked in line.
`timescale 1ns/1ps
module tb_bp_maint_ctrl;

    localparam int unsigned BW    = 2;
    localparam int unsigned PW    = 3;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TW    = 32 - BW - 2;
    localparam int          NSW   = 8;
    localparam int          NBTB  = 4;
    localparam int          NPHT  = 8;

    logic          clk_i = 1'b0;
    logic          rst_i = 1'b1;
    logic          flush_req_i = 1'b0;
    logic          upd_valid_i = 1'b0;
    logic          upd_btb_wr_i = 1'b0;
    logic          upd_pht_wr_i = 1'b0;
    logic [BW-1:0] upd_btb_index_i = '0;
    logic [PW-1:0] upd_pht_index_i = '0;
    logic [TW-1:0] upd_tag_i = '0;
    logic [31:0]   upd_target_i = '0;
    logic          upd_taken_i = 1'b0;
    logic          btb_wren_o, btb_wr_valid_o, pht_wren_o, pht_force_o, pht_taken_o;
    logic          busy_o, upd_drop_o;
    logic [BW-1:0] btb_wr_index_o;
    logic [TW-1:0] btb_wr_tag_o;
    logic [31:0]   btb_wr_target_o;
    logic [PW-1:0] pht_wr_index_o;

    always #5 clk_i = ~clk_i;

    bp_maint_ctrl #(
        .BTB_INDEX_WIDTH(BW),
        .PHT_INDEX_WIDTH(PW),
        .UPD_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .flush_req_i    (flush_req_i),
        .upd_valid_i    (upd_valid_i),
        .upd_btb_wr_i   (upd_btb_wr_i),
        .upd_pht_wr_i   (upd_pht_wr_i),
        .upd_btb_index_i(upd_btb_index_i),
        .upd_pht_index_i(upd_pht_index_i),
        .upd_tag_i      (upd_tag_i),
        .upd_target_i   (upd_target_i),
        .upd_taken_i    (upd_taken_i),
        .btb_wren_o     (btb_wren_o),
        .btb_wr_index_o (btb_wr_index_o),
        .btb_wr_valid_o (btb_wr_valid_o),
        .btb_wr_tag_o   (btb_wr_tag_o),
        .btb_wr_target_o(btb_wr_target_o),
        .pht_wren_o     (pht_wren_o),
        .pht_wr_index_o (pht_wr_index_o),
        .pht_force_o    (pht_force_o),
        .pht_taken_o    (pht_taken_o),
        .busy_o         (busy_o),
        .upd_drop_o     (upd_drop_o)
    );

    typedef struct {
        logic          valid, btb_wr, pht_wr;
        logic [BW-1:0] bi;
        logic [PW-1:0] pi;
        logic [TW-1:0] tag;
        logic [31:0]   tgt;
        logic          taken;
    } upd_s;

    typedef struct {
        logic          btb_en, pht_en;
        logic [BW-1:0] bi;
        logic [PW-1:0] pi;
        logic          valid;
        logic [TW-1:0] tag;
        logic [31:0]   tgt;
        logic          frc, taken;
    } wr_s;

    typedef struct {
        upd_s u;
        logic e_btb, e_pht;
    } vec_s;

    wr_s exp_q[$];
    wr_s mon_e;
    int  checks = 0;
    int  failures = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    function automatic upd_s mku(input logic v, input logic b, input logic p, input int bi,
                                 input int pi, input logic [31:0] tag, input logic [31:0] tgt,
                                 input logic tk);
        upd_s u;
        u.valid = v; u.btb_wr = b; u.pht_wr = p;
        u.bi = BW'(bi); u.pi = PW'(pi); u.tag = TW'(tag); u.tgt = tgt; u.taken = tk;
        return u;
    endfunction

    function automatic vec_s mkv(input upd_s u, input logic eb, input logic ep);
        vec_s v;
        v.u = u; v.e_btb = eb; v.e_pht = ep;
        return v;
    endfunction

    function automatic wr_s upd_wr(input upd_s u);
        wr_s w;
        w.btb_en = u.btb_wr; w.pht_en = u.pht_wr; w.bi = u.bi; w.pi = u.pi;
        w.valid = 1'b1; w.tag = u.tag; w.tgt = u.tgt; w.frc = 1'b0; w.taken = u.taken;
        return w;
    endfunction

    function automatic wr_s sweep_wr(input int i);
        wr_s w;
        w.btb_en = (i < NBTB); w.pht_en = (i < NPHT); w.bi = BW'(i); w.pi = PW'(i);
        w.valid = 1'b0; w.tag = '0; w.tgt = '0; w.frc = 1'b1; w.taken = 1'b0;
        return w;
    endfunction

    task automatic push_sweep(input int n);
        for (int i = 0; i < n; i++) exp_q.push_back(sweep_wr(i));
    endtask

    // Advance to the next sampling point. Pulse inputs drop back to idle here.
    task automatic step();
        @(negedge clk_i);
        upd_valid_i = 1'b0;
        flush_req_i = 1'b0;
    endtask

    task automatic drive(input upd_s u, input bit expect_wr);
        upd_valid_i = u.valid; upd_btb_wr_i = u.btb_wr; upd_pht_wr_i = u.pht_wr;
        upd_btb_index_i = u.bi; upd_pht_index_i = u.pi; upd_tag_i = u.tag;
        upd_target_i = u.tgt; upd_taken_i = u.taken;
        if (expect_wr && u.valid && (u.btb_wr || u.pht_wr)) exp_q.push_back(upd_wr(u));
    endtask

    // Count the cycles with busy high. Return on the first cycle with busy low (bounded wait).
    task automatic count_busy(input string name, output int n);
        bit done;
        done = 1'b0;
        n = 0;
        for (int k = 0; k < 60 && !done; k++) begin
            step();
            if (busy_o) n++;
            else done = 1'b1;
        end
        chk(name, busy_o, 1'b0);
    endtask

    // Scoreboard: every port write must match the oldest expected write.
    always @(negedge clk_i) begin
        if (btb_wren_o === 1'b1 || pht_wren_o === 1'b1) begin
            if (exp_q.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_write: got btb_wren=%0b pht_wren=%0b btb_idx=%0d pht_idx=%0d, expected no write",
                         btb_wren_o, pht_wren_o, btb_wr_index_o, pht_wr_index_o);
            end else begin
                mon_e = exp_q.pop_front();
                chk("wr_btb_en", btb_wren_o, mon_e.btb_en);
                chk("wr_pht_en", pht_wren_o, mon_e.pht_en);
                if (mon_e.btb_en) begin
                    chk("wr_btb_idx", btb_wr_index_o, mon_e.bi);
                    chk("wr_btb_valid", btb_wr_valid_o, mon_e.valid);
                    chk("wr_btb_tag", btb_wr_tag_o, mon_e.tag);
                    chk("wr_btb_target", btb_wr_target_o, mon_e.tgt);
                end
                if (mon_e.pht_en) begin
                    chk("wr_pht_idx", pht_wr_index_o, mon_e.pi);
                    chk("wr_pht_force", pht_force_o, mon_e.frc);
                    if (!mon_e.frc) chk("wr_pht_taken", pht_taken_o, mon_e.taken);
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation still running at 100us, expected to finish");
        $fatal(1);
    end

    initial begin
        vec_s vecs[6];
        upd_s ua, ub, uc, ud;
        int   n, nb, nw;
        logic drop_seen;

        vecs[0] = mkv(mku(1, 1, 1, 3, 5, 32'h1234,    32'h80,       1), 1, 1);
        vecs[1] = mkv(mku(1, 1, 0, 1, 2, 32'hABCDEF0, 32'hDEADBEEC, 0), 1, 0);
        vecs[2] = mkv(mku(1, 0, 1, 2, 7, 32'h0,       32'h0,        1), 0, 1);
        vecs[3] = mkv(mku(1, 0, 0, 1, 1, 32'h55,      32'h44,       1), 0, 0);
        vecs[4] = mkv(mku(0, 1, 1, 0, 3, 32'h66,      32'h48,       1), 0, 0);
        vecs[5] = mkv(mku(1, 0, 1, 0, 0, 32'h0,       32'h0,        0), 0, 1);

        // Reset state.
        step();
        step();
        chk("rst_busy", busy_o, 1'b1);
        chk("rst_btb_wren", btb_wren_o, 1'b0);
        chk("rst_pht_wren", pht_wren_o, 1'b0);
        chk("rst_drop", upd_drop_o, 1'b0);
        chk("rst_target", btb_wr_target_o, 0);
        chk("rst_data", {btb_wr_valid_o, btb_wr_index_o, btb_wr_tag_o, pht_wr_index_o,
                         pht_force_o, pht_taken_o}, 0);

        // Initial sweep after reset release.
        rst_i = 1'b0;
        push_sweep(NSW);
        count_busy("init_busy_fall", n);
        chk("init_busy_len", n, NSW);
        chk("init_sweep_consumed", exp_q.size(), 0);

        // Bypass updates in RUN, one per cycle, with latency 1.
        for (int i = 0; i <= 6; i++) begin
            step();
            if (i > 0) begin
                chk($sformatf("vec%0d_btb_wren", i - 1), btb_wren_o, vecs[i-1].e_btb);
                chk($sformatf("vec%0d_pht_wren", i - 1), pht_wren_o, vecs[i-1].e_pht);
                chk($sformatf("vec%0d_drop", i - 1), upd_drop_o, 1'b0);
                chk($sformatf("vec%0d_busy", i - 1), busy_o, 1'b0);
            end
            if (i < 6) drive(vecs[i].u, 1'b1);
        end

        // A, B and C buffered during a flush sweep. D arrives on the first RUN cycle.
        ua = mku(1, 1, 1, 1, 6, 32'hAAA, 32'h1000, 1);
        ub = mku(1, 1, 0, 2, 0, 32'hBBB, 32'h2004, 0);
        uc = mku(1, 0, 1, 0, 3, 32'h0,   32'h0,    0);
        ud = mku(1, 1, 1, 0, 1, 32'hDDD, 32'h300C, 1);
        step(); flush_req_i = 1'b1; push_sweep(NSW);
        step(); drive(ua, 1'b1);
        step(); drive(ub, 1'b1);
        step(); drive(uc, 1'b1);
        count_busy("abcd_busy_fall", n);
        drive(ud, 1'b1);
        for (int k = 0; k < 4; k++) begin
            step();
            chk($sformatf("abcd_drain%0d_wr", k), btb_wren_o | pht_wren_o, 1'b1);
            chk($sformatf("abcd_drain%0d_drop", k), upd_drop_o, 1'b0);
        end
        step();
        chk("abcd_idle_after", btb_wren_o | pht_wren_o, 1'b0);

        // Five updates during a sweep: four buffered, the fifth dropped.
        step(); flush_req_i = 1'b1; push_sweep(NSW);
        for (int k = 0; k < 5; k++) begin
            step();
            if (k > 0) chk($sformatf("ovf_nodrop%0d", k - 1), upd_drop_o, 1'b0);
            drive(mku(1, 1, 1, k, k + 2, 32'h11 * k, 32'h4000 + 4 * k, k[0]), k < 4);
        end
        step();
        chk("ovf_drop_fifth", upd_drop_o, 1'b1);
        step();
        chk("ovf_drop_pulse_end", upd_drop_o, 1'b0);
        count_busy("ovf_busy_fall", n);
        nw = 0;
        for (int k = 0; k < 8; k++) begin
            if (k > 0) step();
            if (btb_wren_o || pht_wren_o) nw++;
        end
        chk("ovf_drain_count", nw, 4);

        // A flush arriving with sweep index 3 next restarts the sweep at index 0.
        step(); flush_req_i = 1'b1; push_sweep(3);
        nb = 0;
        for (int k = 0; k < 3; k++) begin
            step();
            if (busy_o) nb++;
        end
        step();
        if (busy_o) nb++;
        flush_req_i = 1'b1;
        push_sweep(NSW);
        step();
        if (busy_o) nb++;
        chk("reflush_pht_en", pht_wren_o, 1'b1);
        chk("reflush_pht_idx0", pht_wr_index_o, 0);
        chk("reflush_btb_idx0", {btb_wren_o, btb_wr_index_o}, {1'b1, 2'd0});
        count_busy("reflush_busy_fall", n);
        chk("reflush_busy_len", nb + n, 4 + NSW);

        // Reset while the FIFO holds two entries: those entries must never be written.
        step(); flush_req_i = 1'b1; push_sweep(2);
        step(); drive(mku(1, 1, 1, 3, 4, 32'h77, 32'h5000, 1), 1'b0);
        step(); drive(mku(1, 0, 1, 1, 5, 32'h0,  32'h0,    0), 1'b0);
        step(); rst_i = 1'b1;
        step();
        chk("rst2_busy", busy_o, 1'b1);
        chk("rst2_wren", btb_wren_o | pht_wren_o, 1'b0);
        step(); rst_i = 1'b0; push_sweep(NSW);
        count_busy("rst2_busy_fall", n);
        chk("rst2_busy_len", n, NSW);
        drop_seen = 1'b0;
        nw = 0;
        for (int k = 0; k < 10; k++) begin
            step();
            drop_seen = drop_seen | upd_drop_o;
            if (btb_wren_o || pht_wren_o) nw++;
        end
        chk("rst2_no_drop", drop_seen, 1'b0);
        chk("rst2_no_update_writes", nw, 0);
        chk("scoreboard_empty", exp_q.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
